// File: rtl/i2c_master_write_sequencer_if.sv
// Host/engine bundle for the I2C write sequencer: host request + byte stream,
// write-engine and ACK-read-engine handshakes, status flags.
interface i2c_master_write_sequencer_if #(
    parameter int COUNT_W = 8
);
    logic               start;
    logic [6:0]         slave_addr;
    logic [COUNT_W-1:0] byte_count;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               busy;
    logic               done;
    logic               nack_err;
    logic               timeout_err;
    logic               wr_go;
    logic [2:0]         wr_command;
    logic               wr_data;
    logic               wr_load;
    logic               wr_finish;
    logic               rd_go;
    logic               rd_finish;
    logic               rd_bit;

    // master: the sequencer itself
    modport master (
        input  start, slave_addr, byte_count, tx_data, tx_valid,
        input  wr_load, wr_finish, rd_finish, rd_bit,
        output tx_ready, busy, done, nack_err, timeout_err,
        output wr_go, wr_command, wr_data, rd_go
    );

    // slave: host plus bit engines
    modport slave (
        output start, slave_addr, byte_count, tx_data, tx_valid,
        output wr_load, wr_finish, rd_finish, rd_bit,
        input  tx_ready, busy, done, nack_err, timeout_err,
        input  wr_go, wr_command, wr_data, rd_go
    );
endinterface

// File: rtl/i2c_master_write_sequencer.sv
// I2C write transaction sequencer: START, address+W, N data bytes, STOP.
// Optional engine-wait watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_master_write_sequencer #(
    parameter int COUNT_W        = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic                          clk_i,
    input logic                          rst_i,
    i2c_master_write_sequencer_if.master bus_if
);
    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_FETCH,
        S_DATA, S_DATA_ACK, S_STOP, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               issue_q, issue_d;
    logic [7:0]         shift_q, shift_d;
    logic [6:0]         addr_q, addr_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic               nack_q, nack_d;

    logic               wr_phase, rd_phase, eng_finish, op_done, tx_ready;
    logic [2:0]         wr_command;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               timeout_q, timeout_d;
`endif

    assign wr_phase   = (state_q == S_START) || (state_q == S_ADDR) ||
                        (state_q == S_DATA)  || (state_q == S_STOP);
    assign rd_phase   = (state_q == S_ADDR_ACK) || (state_q == S_DATA_ACK);
    assign eng_finish = wr_phase ? bus_if.wr_finish : bus_if.rd_finish;
    // An op completes on the ISSUE-phase cycle where the engine reports finish.
    assign op_done    = (wr_phase || rd_phase) && issue_q && eng_finish;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            issue_q     <= 1'b0;
            shift_q     <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
            nack_q      <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
            wd_q        <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            issue_q     <= issue_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            nack_q      <= nack_d;
`ifdef I2C_SEQ_TIMEOUT_EN
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        issue_d     = issue_q;
        shift_d     = bus_if.wr_load ? {shift_q[6:0], 1'b0} : shift_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        nack_d      = nack_q;
        tx_ready    = 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
        wd_d        = '0;
        timeout_d   = timeout_q;
`endif

        // WAIT_LOW -> ISSUE once the engine has dropped finish from the previous op
        if ((wr_phase || rd_phase) && !issue_q && !eng_finish) begin
            issue_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus_if.start) begin
                    addr_d      = bus_if.slave_addr;
                    remaining_d = bus_if.byte_count;
                    nack_d      = 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
                    timeout_d   = 1'b0;
`endif
                    issue_d     = 1'b0;
                    state_d     = S_START;
                end
            end
            S_START: begin
                if (op_done) begin
                    shift_d = {addr_q, 1'b0};
                    issue_d = 1'b0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (op_done) begin
                    issue_d = 1'b0;
                    state_d = S_ADDR_ACK;
                end
            end
            S_ADDR_ACK, S_DATA_ACK: begin
                if (op_done) begin
                    issue_d = 1'b0;
                    if (bus_if.rd_bit) begin
                        nack_d  = 1'b1;
                        state_d = S_STOP;
                    end else if (remaining_q == '0) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (bus_if.tx_valid) begin
                    tx_ready    = 1'b1;
                    shift_d     = bus_if.tx_data;
                    remaining_d = remaining_q - COUNT_W'(1);
                    issue_d     = 1'b0;
                    state_d     = S_DATA;
                end
            end
            S_DATA: begin
                if (op_done) begin
                    issue_d = 1'b0;
                    state_d = S_DATA_ACK;
                end
            end
            S_STOP: begin
                if (op_done) begin
                    issue_d = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef I2C_SEQ_TIMEOUT_EN
        // Watchdog restarts on every phase change; expiry abandons the bus without STOP
        if (wr_phase || rd_phase) begin
            if ((issue_d != issue_q) || (state_d != state_q)) begin
                wd_d = '0;
            end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                timeout_d = 1'b1;
                issue_d   = 1'b0;
                state_d   = S_DONE;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
`endif
    end

    always_comb begin
        case (state_q)
            S_START:        wr_command = 3'b001;
            S_ADDR, S_DATA: wr_command = 3'b011;
            S_STOP:         wr_command = 3'b100;
            default:        wr_command = 3'b000;
        endcase
    end

    // go strobes decode straight from registered state so reset drops them at once
    assign bus_if.wr_go      = wr_phase && issue_q;
    assign bus_if.rd_go      = rd_phase && issue_q;
    assign bus_if.wr_command = wr_command;
    assign bus_if.wr_data    = shift_q[7];
    assign bus_if.tx_ready   = tx_ready;
    assign bus_if.busy       = (state_q != S_IDLE);
    assign bus_if.done       = (state_q == S_DONE);
    assign bus_if.nack_err   = nack_q;
`ifdef I2C_SEQ_TIMEOUT_EN
    assign bus_if.timeout_err = timeout_q;
`else
    assign bus_if.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_master_write_sequencer.sv
// Directed bench for i2c_master_write_sequencer with bus-engine models and an op scoreboard.
module tb_i2c_master_write_sequencer;
    localparam int COUNT_W = 8;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_master_write_sequencer_if #(.COUNT_W(COUNT_W)) bus ();

    i2c_master_write_sequencer #(
        .COUNT_W(COUNT_W),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus_if(bus)
    );

    int tests = 0;
    int fails = 0;

    logic [10:0] exp_q[$];   // {command, byte} expected per engine op
    logic [7:0]  src[$];     // host byte stream
    int  exp_tx, tx_cnt, done_cnt, ack_idx, nack_at, ops_started, go_cycles, overlap;
    bit  exp_nack, tx_hold, wr_stuck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write bit/byte engine model: records each op and the bits it serialises
    logic [2:0]  w_cmd;
    logic [7:0]  w_byte;
    logic [10:0] w_exp;
    bit          w_abort;
    initial begin
        bus.wr_load   = 1'b0;
        bus.wr_finish = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.wr_go && !wr_stuck) begin
                w_cmd   = bus.wr_command;
                w_byte  = 8'h00;
                w_abort = 1'b0;
                ops_started++;
                if (w_cmd == 3'b011) begin
                    for (int i = 0; i < 8; i++) begin
                        if (!bus.wr_go) begin
                            w_abort = 1'b1;
                            break;
                        end
                        w_byte = {w_byte[6:0], bus.wr_data};
                        bus.wr_load = 1'b1;
                        @(negedge clk);
                        bus.wr_load = 1'b0;
                    end
                end
                if (!w_abort) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $error("FAIL op_unexpected: observed cmd %0b byte %0h expected none", w_cmd, w_byte);
                    end else begin
                        w_exp = exp_q.pop_front();
                        assert ({w_cmd, w_byte} === w_exp) else begin
                            fails++;
                            $error("FAIL op: observed cmd %0b byte %0h expected cmd %0b byte %0h",
                                   w_cmd, w_byte, w_exp[10:8], w_exp[7:0]);
                        end
                    end
                    $display("[TB] op cmd=%0b byte=%02h", w_cmd, w_byte);
                    bus.wr_finish = 1'b1;
                    for (int k = 0; k < 100 && bus.wr_go; k++) @(negedge clk);
                    bus.wr_finish = 1'b0;
                end
            end
        end
    end

    // ACK-read engine model: NACKs on ACK slot number nack_at (0 = address ACK)
    initial begin
        bus.rd_finish = 1'b0;
        bus.rd_bit    = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.rd_go) begin
                bus.rd_bit    = (ack_idx == nack_at);
                ack_idx++;
                bus.rd_finish = 1'b1;
                for (int k = 0; k < 100 && bus.rd_go; k++) @(negedge clk);
                bus.rd_finish = 1'b0;
                bus.rd_bit    = 1'b0;
            end
        end
    end

    // Host byte source; tx_valid is offered whenever a byte is queued
    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (src.size() > 0 && !tx_hold) begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = src[0];
            end else begin
                bus.tx_valid = 1'b0;
                bus.tx_data  = 8'h00;
            end
            #1;
            if (bus.tx_ready) begin
                tx_cnt++;
                if (src.size() > 0) void'(src.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.done)  done_cnt++;
            if (bus.wr_go) go_cycles++;
            if (bus.wr_go && bus.rd_go) overlap++;
        end
    end

    task automatic pulse_start(input logic [6:0] a, input int n);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.slave_addr = a;
        bus.byte_count = COUNT_W'(n);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic begin_txn(input logic [6:0] a, input int n, input int nk,
                             input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] bs[3];
        bs = '{b0, b1, b2};
        exp_tx = 0; tx_cnt = 0; done_cnt = 0; ack_idx = 0; nack_at = nk;
        exp_q.push_back({3'b001, 8'h00});
        exp_q.push_back({3'b011, a, 1'b0});
        for (int i = 0; i < n; i++) src.push_back(bs[i]);
        if (nk != 0) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({3'b011, bs[i]});
                exp_tx++;
                if (nk == i + 1) break;
            end
        end
        exp_q.push_back({3'b100, 8'h00});
        exp_nack = (nk >= 0) && (nk <= n);
        pulse_start(a, n);
        check("nack_clr_on_start", 32'(bus.nack_err), 32'd0);
        check("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    task automatic finish_txn(input string tag);
        for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
        check("done_seen", 32'(done_cnt != 0), 32'd1);
        repeat (3) @(negedge clk);
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("tx_ready_pulses", 32'(tx_cnt), 32'(exp_tx));
        check("nack_err", 32'(bus.nack_err), 32'(exp_nack));
        check("busy_idle", 32'(bus.busy), 32'd0);
        check("ops_left", 32'(exp_q.size()), 32'd0);
        check("timeout_err_clear", 32'(bus.timeout_err), 32'd0);
        $display("[TB] txn %s done tx=%0d nack=%0b", tag, tx_cnt, bus.nack_err);
        src.delete();
        exp_q.delete();
    endtask

    int viol;
    int base;
    initial begin
        bus.start = 1'b0; bus.slave_addr = 7'h00; bus.byte_count = '0;
        tx_hold = 1'b0; wr_stuck = 1'b0; nack_at = -1; ack_idx = 0;
        ops_started = 0; go_cycles = 0; overlap = 0; done_cnt = 0; tx_cnt = 0;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_wr_go", 32'(bus.wr_go), 32'd0);
        check("rst_rd_go", 32'(bus.rd_go), 32'd0);
        check("rst_cmd", 32'(bus.wr_command), 32'd0);
        check("rst_wr_data", 32'(bus.wr_data), 32'd0);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
        check("rst_nack", 32'(bus.nack_err), 32'd0);
        rst = 1'b0;

        // Two data bytes, all ACK
        begin_txn(7'h50, 2, -1, 8'hAC, 8'h35, 8'h00);
        finish_txn("write2");

        // Address-only probe
        begin_txn(7'h3C, 0, -1, 8'h00, 8'h00, 8'h00);
        finish_txn("probe");

        // NACK on second data ACK: third byte must never be fetched
        begin_txn(7'h50, 3, 2, 8'h11, 8'h22, 8'h33);
        finish_txn("nack");
        repeat (5) @(negedge clk);
        check("nack_sticky", 32'(bus.nack_err), 32'd1);

        // NACK on the address
        begin_txn(7'h2A, 2, 0, 8'h44, 8'h55, 8'h00);
        finish_txn("addr_nack");

        // Host stalls in FETCH; a second start during the stall must be ignored
        tx_hold = 1'b1;
        begin_txn(7'h22, 1, -1, 8'h5A, 8'h00, 8'h00);
        for (int i = 0; i < 2000 && !(ack_idx == 1 && !bus.rd_go); i++) @(negedge clk);
        check("fetch_reached", 32'(ack_idx), 32'd1);
        viol = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.wr_go || !bus.busy) viol++;
            if (i == 10) begin
                bus.start = 1'b1; bus.slave_addr = 7'h11; bus.byte_count = 8'd5;
            end
            if (i == 11) bus.start = 1'b0;
        end
        check("stall_wr_go_low_busy_high", 32'(viol), 32'd0);
        tx_hold = 1'b0;
        finish_txn("stall");

        // Reset in the middle of the first data byte
        base = ops_started;
        begin_txn(7'h50, 2, -1, 8'hAC, 8'h35, 8'h00);
        for (int i = 0; i < 2000 && !(ops_started == base + 3 && bus.wr_go); i++) @(negedge clk);
        check("mid_data_reached", 32'(ops_started - base), 32'd3);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_wr_go", 32'(bus.wr_go), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_cmd", 32'(bus.wr_command), 32'd0);
        repeat (3) @(negedge clk);
        exp_q.delete();
        src.delete();
        rst = 1'b0;
        $display("[TB] reset abort applied");

        begin_txn(7'h50, 2, -1, 8'hC3, 8'h0F, 8'h00);
        finish_txn("after_reset");

`ifdef I2C_SEQ_TIMEOUT_EN
        // Write engine never finishes: watchdog ends the transfer without STOP
        wr_stuck = 1'b1;
        done_cnt = 0;
        go_cycles = 0;
        pulse_start(7'h50, 1);
        for (int i = 0; i < 500 && done_cnt == 0; i++) @(negedge clk);
        check("to_done_seen", 32'(done_cnt), 32'd1);
        check("to_go_cycles", 32'(go_cycles), 32'(TIMEOUT));
        check("to_err", 32'(bus.timeout_err), 32'd1);
        repeat (2) @(negedge clk);
        check("to_busy", 32'(bus.busy), 32'd0);
        check("to_done_pulses", 32'(done_cnt), 32'd1);
        $display("[TB] timeout txn done err=%0b", bus.timeout_err);
        wr_stuck = 1'b0;
        repeat (3) @(negedge clk);
`endif

        begin_txn(7'h7F, 1, -1, 8'hFF, 8'h00, 8'h00);
        finish_txn("final");

        check("go_overlap", 32'(overlap), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: observed running expected finished");
        $fatal(1, "global timeout");
    end
endmodule

// File: doc/i2c_master_write_sequencer.md
Name: i2c_master_write_sequencer

Overview:
- Transaction-level controller that drives I2C_master_write_byte (bit/byte engine) and an ACK-read bit engine to perform a complete I2C write: START, 7-bit address + W, N data bytes, STOP.
- Sits between a host-side request/byte stream and the bus engines.
- Owns engine handshakes, byte shift register, ACK checking and error reporting.

Parameters:
- COUNT_W, 8, width of byte_count; max transfer 2^COUNT_W-1 bytes.
- TIMEOUT_CYCLES, 4096, engine-wait watchdog limit; used only with I2C_SEQ_TIMEOUT_EN.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; accepted only when busy=0.
- slave_addr  in  7  target address, captured on accepted start.
- byte_count  in  COUNT_W  data bytes to send, captured on accepted start.
- tx_data  in  8  next data byte.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  one-cycle pulse; byte consumed when tx_valid & tx_ready.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after STOP completes.
- nack_err  out  1  sticky; slave NACKed; cleared on next accepted start.
- timeout_err  out  1  sticky; watchdog fired; constant 0 without macro.
- wr_go  out  1  go to write engine.
- wr_command  out  3  command to write engine.
- wr_data  out  1  serial bit, shift_reg[7].
- wr_load  in  1  engine shift strobe.
- wr_finish  in  1  engine finish.
- rd_go  out  1  go to ACK-read engine.
- rd_finish  in  1  ACK-read finish.
- rd_bit  in  1  sampled SDA; 0=ACK, 1=NACK.

Behaviour:
- Reset values: all outputs 0, wr_command=3'b000, shift_reg=0, state IDLE. Reset mid-transaction aborts immediately; wr_go/rd_go drop asynchronously; no STOP issued.
- Command codes: 3'b000 idle, 3'b001 START, 3'b011 write byte, 3'b100 STOP.
- Engine handshake (each op): WAIT_LOW phase: go=0 until finish=0. ISSUE phase: go=1 with command stable until finish=1. On the cycle finish=1 is sampled: go<=0, next op. Command changes only while go=0.
- shift_reg: when wr_load=1 at a clock edge, shift_reg <= {shift_reg[6:0],1'b0}; loading has priority over nothing else (loads never coincide with byte capture).
- States:
  - IDLE: busy=0. start=1 captures addr/count, clears nack_err/timeout_err, busy<=1 -> START.
  - START: op 3'b001 -> ADDR.
  - ADDR: shift_reg<={slave_addr,1'b0}; op 3'b011 -> ADDR_ACK.
  - ADDR_ACK / DATA_ACK: rd_go handshake; rd_bit sampled when rd_finish=1. rd_bit=1: nack_err<=1 -> STOP. rd_bit=0: remaining==0 -> STOP, else FETCH.
  - FETCH: tx_ready=1 for one cycle when tx_valid=1; shift_reg<=tx_data, remaining-=1 -> DATA. tx_valid=0: hold; SCL held low by engine.
  - DATA: op 3'b011 -> DATA_ACK.
  - STOP: op 3'b100 -> DONE.
  - DONE: done=1 one cycle, busy<=0 -> IDLE.
- byte_count=0: address-only probe (START, ADDR, ADDR_ACK, STOP).
- start while busy=1 ignored. tx_valid outside FETCH ignored.
- Never more than one of wr_go/rd_go high.

Optional Feature:
- I2C_SEQ_TIMEOUT_EN: watchdog counts cycles in any ISSUE/WAIT_LOW phase; resets at each phase change. At TIMEOUT_CYCLES: go outputs 0, timeout_err<=1, -> DONE (no STOP). Without macro: no counter, timeout_err tied 0, waits are unbounded.

Test Plan:
- addr=7'h50, count=2, bytes 8'hAC,8'h35, all ACK -> wr_command sequence 001,011,011,011,100; wr_data serialises 8'hA0,8'hAC,8'h35 MSB first; tx_ready exactly 2 pulses; done 1 pulse; nack_err=0.
- addr=7'h3C, count=0, ACK -> ops 001,011,100 only; no tx_ready; done pulses.
- addr=7'h50, count=3, rd_bit=1 on 2nd data ACK -> STOP follows immediately; 3rd byte never requested; nack_err=1 until next start.
- count=1, tx_valid withheld 50 cycles in FETCH -> wr_go stays 0, busy=1; byte sent after tx_valid rises.
- reset asserted mid-DATA -> wr_go=0 same cycle, busy=0; new start afterwards runs full sequence correctly.
- I2C_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=64, wr_finish stuck 0 -> timeout_err=1 after 64 cycles, done pulses, busy=0.
